// File: rtl/requantize_sf_sequencer_pkg.sv
// Shared requantizer definitions: band-walk FSM encoding and default geometry.
package requantize_sf_sequencer_pkg;

  localparam int NUM_SFB_DEF  = 22;
  localparam int SF_WIDTH_DEF = 4;
  localparam int SFB_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

endpackage

// File: rtl/requantize_sf_sequencer.sv
// Walks long-block scalefactor bands, fetching scalefac_l and pretab per band and
// emitting the requantizer exponent offset over a valid/ready handshake.
module requantize_sf_sequencer
  import requantize_sf_sequencer_pkg::*;
#(
  parameter int NUM_SFB  = NUM_SFB_DEF,
  parameter int SF_WIDTH = SF_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  preflag,
  input  logic                  scalefac_scale,
  output logic                  busy,
  output logic                  done,
  output logic                  pretab_en,
  output logic [SFB_W-1:0]      pretab_cb,
  input  logic [1:0]            pretab_data,
  output logic                  sf_en,
  output logic [SFB_W-1:0]      sf_addr,
  input  logic [SF_WIDTH-1:0]   sf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SFB_W-1:0]      out_sfb,
  output logic [SF_WIDTH+2:0]   out_shift,
  output logic                  out_last
);

  localparam int OW = SF_WIDTH + 3;
  localparam logic [SFB_W-1:0] LAST_SFB = SFB_W'(NUM_SFB - 1);

  state_t            state, state_next;
  logic [SFB_W-1:0]  sfb;
  logic              preflag_q, scale_q;
  logic [OW-1:0]     shift_p1;
  logic              done_q;
  logic              accept, handshake, is_last;

  // Widened sum so the largest case (15 + 3) << 2 = 72 never truncates.
  function automatic logic [OW-1:0] scale_shift(
    input logic [SF_WIDTH-1:0] sf,
    input logic [1:0]          pt,
    input logic                use_pt,
    input logic                scale
  );
    logic [OW-1:0] sum;
    sum = OW'(sf) + OW'(use_pt ? pt : 2'd0);
    return scale ? (sum << 2) : (sum << 1);
  endfunction

  assign handshake = (state == ST_OUT) && out_ready;
  assign is_last   = (sfb == LAST_SFB);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_READ;
          accept     = 1'b1;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_OUT;
      ST_OUT: begin
        if (handshake) state_next = is_last ? ST_IDLE : ST_READ;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sfb       <= '0;
      preflag_q <= 1'b0;
      scale_q   <= 1'b0;
      shift_p1  <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= handshake && is_last;
      if (accept) begin
        sfb       <= '0;
        preflag_q <= preflag;
        scale_q   <= scalefac_scale;
      end else if (handshake && !is_last) begin
        sfb <= sfb + SFB_W'(1);
      end
      // Stage p1: RAM/ROM data returned one cycle after READ is folded here.
      if (state == ST_CAPTURE)
        shift_p1 <= scale_shift(sf_data, pretab_data, preflag_q, scale_q);
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign sf_en     = (state == ST_READ);
  assign sf_addr   = sfb;
  assign pretab_en = (state == ST_READ) && preflag_q;
  assign pretab_cb = sfb;
  assign out_valid = (state == ST_OUT);
  assign out_sfb   = sfb;
  assign out_shift = shift_p1;
  assign out_last  = (state == ST_OUT) && is_last;

endmodule

// File: tb/tb_requantize_sf_sequencer.sv
// Scoreboard bench for requantize_sf_sequencer with behavioural scalefactor RAM and pretab ROM.
module tb_requantize_sf_sequencer;

  typedef struct {
    logic [4:0] sfb;
    logic [6:0] shift;
    logic       last;
    int         cyc;
  } word_t;

  logic       clk, rst_n, start, preflag, scalefac_scale, out_ready;
  logic       busy, done, pretab_en, sf_en, out_valid, out_last;
  logic [4:0] pretab_cb, sf_addr, out_sfb;
  logic [1:0] pretab_data;
  logic [3:0] sf_data;
  logic [6:0] out_shift;

  logic [3:0] ram [0:31];
  logic [1:0] pretab_rom [0:31];

  word_t exp_q [$];
  word_t obs [0:511];
  int obs_n = 0, done_n = 0, done_cyc = 0, sf_rd = 0, pt_rd = 0, cyc = 0;
  int rd = 0, errors = 0, checks = 0;

  requantize_sf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .preflag(preflag),
    .scalefac_scale(scalefac_scale), .busy(busy), .done(done),
    .pretab_en(pretab_en), .pretab_cb(pretab_cb), .pretab_data(pretab_data),
    .sf_en(sf_en), .sf_addr(sf_addr), .sf_data(sf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sfb(out_sfb),
    .out_shift(out_shift), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sf_en) sf_data <= ram[sf_addr];
    if (pretab_en) pretab_data <= pretab_rom[pretab_cb];
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      obs[obs_n].sfb   <= out_sfb;
      obs[obs_n].shift <= out_shift;
      obs[obs_n].last  <= out_last;
      obs[obs_n].cyc   <= cyc;
      obs_n <= obs_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (sf_en) sf_rd <= sf_rd + 1;
    if (pretab_en) pt_rd <= pt_rd + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_walk(input logic pf, input logic sc);
    for (int k = 0; k < 22; k++) begin
      word_t w;
      int v;
      v = (int'(ram[k]) + (pf ? int'(pretab_rom[k]) : 0)) * (sc ? 4 : 2);
      w.sfb = 5'(k); w.shift = 7'(v); w.last = (k == 21); w.cyc = 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; preflag = 1'b1; scalefac_scale = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b need 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b need 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b need 0", out_last); end
    checks++; if (sf_en !== 1'b0 || pretab_en !== 1'b0) begin errors++; $display("FAIL reset_en got sf=%b pt=%b need 0 0", sf_en, pretab_en); end
    checks++; if (out_shift !== 7'd0 || out_sfb !== 5'd0) begin errors++; $display("FAIL reset_word got shift=%0d sfb=%0d need 0 0", out_shift, out_sfb); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_plain_walk();
    int s, first, d0, sf0, pt0;
    logic busy_at_done;
    for (int k = 0; k < 32; k++) ram[k] = 4'(k % 16);
    push_walk(1'b0, 1'b0);
    d0 = done_n; sf0 = sf_rd; pt0 = pt_rd; first = -1; busy_at_done = 1'b1;
    preflag = 1'b0; scalefac_scale = 1'b0; out_ready = 1'b1;
    start = 1'b1; s = cyc;
    tick();
    for (int i = 0; i < 300 && done_n == d0; i++) begin
      start = 1'b0;
      if (first < 0 && out_valid) first = cyc;
      if (done) busy_at_done = busy;
      tick();
    end
    checks++; if (first - s !== 3) begin errors++; $display("FAIL plain_first_latency got %0d need 3", first - s); end
    // Busy spans cycles s+1..s+66; done is the cycle after.
    checks++; if (done_cyc - (s + 1) !== 66) begin errors++; $display("FAIL plain_done_cycle got %0d need 66", done_cyc - (s + 1)); end
    checks++; if (done_n !== d0 + 1) begin errors++; $display("FAIL plain_done_count got %0d need %0d", done_n, d0 + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL plain_busy_at_done got %b need 0", busy_at_done); end
    checks++; if (pt_rd - pt0 !== 0) begin errors++; $display("FAIL plain_pretab_reads got %0d need 0", pt_rd - pt0); end
    checks++; if (sf_rd - sf0 !== 22) begin errors++; $display("FAIL plain_sf_reads got %0d need 22", sf_rd - sf0); end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL plain_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL plain_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
    checks++; if (rd !== obs_n) begin errors++; $display("FAIL plain_extra_words got %0d need %0d", obs_n, rd); end
  endtask

  task automatic test_preflag();
    int d0, pt0, base;
    for (int k = 0; k < 32; k++) ram[k] = 4'((k * 7 + 3) % 16);
    ram[17] = 4'd5; ram[11] = 4'd0;
    push_walk(1'b1, 1'b0);
    d0 = done_n; pt0 = pt_rd; base = rd;
    preflag = 1'b1; scalefac_scale = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 300 && done_n == d0; i++) begin
      start = 1'b0;
      tick();
    end
    checks++; if (obs[base + 17].shift !== 7'd16) begin errors++; $display("FAIL preflag_sfb17 got %0d need 16", obs[base + 17].shift); end
    checks++; if (obs[base + 11].shift !== 7'd2) begin errors++; $display("FAIL preflag_sfb11 got %0d need 2", obs[base + 11].shift); end
    checks++; if (obs[base + 21].last !== 1'b1 || obs[base + 21].shift !== 7'(2 * ram[21])) begin
      errors++; $display("FAIL preflag_sfb21 got last=%b shift=%0d need last=1 shift=%0d", obs[base + 21].last, obs[base + 21].shift, 2 * ram[21]);
    end
    checks++; if (pt_rd - pt0 !== 22) begin errors++; $display("FAIL preflag_pretab_reads got %0d need 22", pt_rd - pt0); end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL preflag_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL preflag_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
  endtask

  task automatic test_scale();
    int d0, base;
    for (int k = 0; k < 32; k++) ram[k] = 4'd15;
    push_walk(1'b1, 1'b1);
    d0 = done_n; base = rd;
    preflag = 1'b1; scalefac_scale = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    preflag = 1'b0; scalefac_scale = 1'b0;
    for (int i = 0; i < 300 && done_n == d0; i++) begin
      start = 1'b0;
      tick();
    end
    checks++; if (obs[base + 17].shift !== 7'd72) begin errors++; $display("FAIL scale_sfb17 got %0d need 72", obs[base + 17].shift); end
    checks++; if (obs[base].shift !== 7'd60) begin errors++; $display("FAIL scale_sfb0 got %0d need 60", obs[base].shift); end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL scale_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL scale_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
  endtask

  task automatic test_stall();
    int d0, sf0, pt0, base;
    logic stalled;
    logic [4:0] h_sfb;
    logic [6:0] h_shift;
    for (int k = 0; k < 32; k++) ram[k] = 4'(k % 16);
    push_walk(1'b1, 1'b0);
    d0 = done_n; base = rd; stalled = 1'b0; sf0 = 0; pt0 = 0;
    preflag = 1'b1; scalefac_scale = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 400 && done_n == d0; i++) begin
      start = 1'b0;
      if (!stalled && out_valid && out_sfb == 5'd3) begin
        stalled = 1'b1; h_sfb = out_sfb; h_shift = out_shift;
        out_ready = 1'b0; sf0 = sf_rd; pt0 = pt_rd;
        for (int j = 0; j < 5; j++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_sfb !== h_sfb || out_shift !== h_shift) begin
            errors++; $display("FAIL stall_hold got v=%b sfb=%0d shift=%0d need v=1 sfb=%0d shift=%0d", out_valid, out_sfb, out_shift, h_sfb, h_shift);
          end
        end
        out_ready = 1'b1;
        checks++; if (sf_rd !== sf0 || pt_rd !== pt0) begin errors++; $display("FAIL stall_reads got sf=%0d pt=%0d need 0 0", sf_rd - sf0, pt_rd - pt0); end
      end
      tick();
    end
    checks++; if (obs[base + 4].cyc - obs[base + 3].cyc !== 3) begin
      errors++; $display("FAIL stall_next_latency got %0d need 3", obs[base + 4].cyc - obs[base + 3].cyc);
    end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL stall_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL stall_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic hit;
    for (int k = 0; k < 32; k++) ram[k] = 4'((k * 5 + 1) % 16);
    d0 = done_n; hit = 1'b0;
    preflag = 1'b1; scalefac_scale = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 300 && !hit; i++) begin
      start = 1'b0;
      if (out_valid && out_sfb == 5'd10) hit = 1'b1;
      else tick();
    end
    out_ready = 1'b0; rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, out_valid, out_last, pretab_en, sf_en, out_shift, out_sfb} !== 17'd0) begin
      errors++; $display("FAIL midreset_outputs got busy=%b done=%b v=%b last=%b pt=%b sf=%b shift=%0d sfb=%0d need all 0", busy, done, out_valid, out_last, pretab_en, sf_en, out_shift, out_sfb);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (done_n !== d0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_done got done_events=%0d busy=%b need 0 0", done_n - d0, busy); end
    rd = obs_n;
    push_walk(1'b0, 1'b0);
    preflag = 1'b0; scalefac_scale = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 300 && done_n == d0; i++) begin
      start = 1'b0;
      tick();
    end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL midreset_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL midreset_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic pulsed, second, chk_busy;
    for (int k = 0; k < 32; k++) ram[k] = 4'($urandom_range(0, 15));
    push_walk(1'b0, 1'b1);
    d0 = done_n; pulsed = 1'b0; second = 1'b0; chk_busy = 1'b0;
    preflag = 1'b0; scalefac_scale = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 400 && done_n < d0 + 2; i++) begin
      start = 1'b0;
      if (chk_busy) begin
        chk_busy = 1'b0; checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b need 1", busy); end
      end
      if (!pulsed && out_valid && out_sfb == 5'd5) begin
        pulsed = 1'b1; start = 1'b1; preflag = 1'b1; scalefac_scale = 1'b0;
      end else if (done && !second) begin
        second = 1'b1; chk_busy = 1'b1; start = 1'b1;
        preflag = 1'b1; scalefac_scale = 1'b0;
        push_walk(1'b1, 1'b0);
      end
      tick();
    end
    checks++; if (done_n !== d0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d need 2", done_n - d0); end
    while (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_n) begin errors++; $display("FAIL b2b_word missing got none need sfb=%0d", e.sfb); end
      else begin
        if (obs[rd].sfb !== e.sfb || obs[rd].shift !== e.shift || obs[rd].last !== e.last) begin
          errors++; $display("FAIL b2b_word got sfb=%0d shift=%0d last=%b need sfb=%0d shift=%0d last=%b", obs[rd].sfb, obs[rd].shift, obs[rd].last, e.sfb, e.shift, e.last);
        end
        rd++;
      end
    end
    checks++; if (rd !== obs_n) begin errors++; $display("FAIL b2b_extra_words got %0d need %0d", obs_n, rd); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      pretab_rom[k] = 2'd0;
      ram[k] = 4'd0;
    end
    for (int k = 11; k <= 14; k++) pretab_rom[k] = 2'd1;
    pretab_rom[15] = 2'd2; pretab_rom[16] = 2'd2;
    pretab_rom[17] = 2'd3; pretab_rom[18] = 2'd3; pretab_rom[19] = 2'd3;
    pretab_rom[20] = 2'd2;
    pretab_data = 2'd0; sf_data = 4'd0;
    test_reset();
    test_plain_walk();
    test_preflag();
    test_scale();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
